// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between the fetch stage and the MEM stage.
// Data requests win over fetches. A BUSY state that waits too long for m_ready ends in a sticky error state.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_done_q, d_done_d;
    logic        bus_err_q, bus_err_d;

    logic        d_req;
    logic        f_req;
    logic        timeout_hit;

    // A request is masked during its own done cycle, so a held request is not re-issued.
    assign d_req       = (d_read | d_write) & ~d_done_q;
    assign f_req       = if_req & ~if_valid_q;
    assign timeout_hit = ((cnt_q + 16'd1) == TIMEOUT_CNT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        if_valid_d = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_done_d   = 1'b0;
        bus_err_d  = bus_err_q;

        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d   = DBUSY;
                    cnt_d     = 16'd0;
                    m_req_d   = 1'b1;
                    m_we_d    = d_write;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (f_req) begin
                    state_d  = IBUSY;
                    cnt_d    = 16'd0;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = if_addr;
                end
            end

            DBUSY, IBUSY: begin
                if (m_ready) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (state_q == DBUSY) begin
                        d_done_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d   = ERR;
                    cnt_d     = cnt_q + 16'd1;
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ERR: begin
                m_req_d   = 1'b0;
                m_we_d    = 1'b0;
                bus_err_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            if_rdata_q <= 32'd0;
            if_valid_q <= 1'b0;
            d_rdata_q  <= 32'd0;
            d_done_q   <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            if_valid_q <= if_valid_d;
            d_rdata_q  <= d_rdata_d;
            d_done_q   <= d_done_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Stalls are combinational so the pipeline can hold in the same cycle it asks for memory.
    always_comb begin
        stall_mem = (d_read | d_write) & ~d_done_q;
        stall_if  = (if_req & ~if_valid_q) | stall_mem;
        if (state_q == ERR) begin
            stall_mem = 1'b1;
            stall_if  = 1'b1;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign if_valid = if_valid_q;
    assign d_rdata  = d_rdata_q;
    assign d_done   = d_done_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The main instance uses TIMEOUT=4.
// A second instance with the default TIMEOUT covers the long wait-state sequence.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_valid, d_done, m_req, m_we, stall_if, stall_mem, bus_err;

    logic [31:0] l_if_rdata, l_d_rdata, l_m_addr, l_m_wdata;
    logic        l_if_valid, l_d_done, l_m_req, l_m_we, l_stall_if, l_stall_mem, l_bus_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    mem_port_arbiter dut_l (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(l_if_rdata), .if_valid(l_if_valid),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(l_d_rdata), .d_done(l_d_done),
        .m_req(l_m_req), .m_we(l_m_we), .m_addr(l_m_addr), .m_wdata(l_m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_if(l_stall_if), .stall_mem(l_stall_mem), .bus_err(l_bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_read = 0; d_write = 0;
        d_addr = 0; d_wdata = 0; m_rdata = 0; m_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic if_req, d_read, d_write;
        logic exp_stall_if, exp_stall_mem;
    } stall_vec_t;

    typedef struct {
        logic        if_req, d_read, d_write;
        logic [31:0] if_addr, d_addr, d_wdata;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wdata;
    } issue_vec_t;

    stall_vec_t sv[8];
    issue_vec_t iv[5];

    initial begin
        for (int i = 0; i < 8; i++) begin
            sv[i].if_req  = i[2];
            sv[i].d_read  = i[1];
            sv[i].d_write = i[0];
            sv[i].exp_stall_mem = (i[1] | i[0]);
            sv[i].exp_stall_if  = (i[2] | i[1] | i[0]);
        end
        // if_req, d_read, d_write, if_addr, d_addr, d_wdata, exp_we, exp_addr, exp_wdata
        iv[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'h1111_1111, 1'b0, 32'h0000_0100, 32'h1111_1111};
        iv[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0200, 32'h0000_0055, 1'b1, 32'h0000_0200, 32'h0000_0055};
        iv[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 32'hCAFE_F00D, 1'b1, 32'h0000_0300, 32'hCAFE_F00D};
        iv[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0999, 32'h2222_2222, 1'b0, 32'h0000_0040, 32'h0000_0000};
        iv[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0000_0500, 32'h3333_3333, 1'b1, 32'h0000_0500, 32'h3333_3333};

        idle_inputs();
        rst = 1;
        #12;
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_d_done", {31'd0, d_done}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);

        // Stall decode while held in reset (IDLE, no done pulses).
        for (int i = 0; i < 8; i++) begin
            if_req = sv[i].if_req; d_read = sv[i].d_read; d_write = sv[i].d_write;
            #1;
            check($sformatf("stall_if[%0d]", i), {31'd0, stall_if}, {31'd0, sv[i].exp_stall_if});
            check($sformatf("stall_mem[%0d]", i), {31'd0, stall_mem}, {31'd0, sv[i].exp_stall_mem});
        end

        // Issue decode and priority, one IDLE edge per vector.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            if_req = iv[i].if_req; d_read = iv[i].d_read; d_write = iv[i].d_write;
            if_addr = iv[i].if_addr; d_addr = iv[i].d_addr; d_wdata = iv[i].d_wdata;
            tick();
            check($sformatf("iss_req[%0d]", i), {31'd0, m_req}, 32'd1);
            check($sformatf("iss_we[%0d]", i), {31'd0, m_we}, {31'd0, iv[i].exp_we});
            check($sformatf("iss_addr[%0d]", i), m_addr, iv[i].exp_addr);
            check($sformatf("iss_wdata[%0d]", i), m_wdata, iv[i].exp_wdata);
        end

        // Minimum-latency load.
        do_reset();
        d_read = 1; d_addr = 32'h100;
        #1;
        check("ld_stall_N", {31'd0, stall_mem}, 32'd1);
        tick();
        check("ld_mreq_N1", {31'd0, m_req}, 32'd1);
        check("ld_stall_N1", {31'd0, stall_mem}, 32'd1);
        check("ld_done_N1", {31'd0, d_done}, 32'd0);
        m_ready = 1; m_rdata = 32'hDEAD_BEEF;
        tick();
        check("ld_done_N2", {31'd0, d_done}, 32'd1);
        check("ld_rdata", d_rdata, 32'hDEAD_BEEF);
        check("ld_mreq_N2", {31'd0, m_req}, 32'd0);
        check("ld_stall_N2", {31'd0, stall_mem}, 32'd0);
        d_read = 0; m_ready = 0;
        tick();
        check("ld_done_pulse", {31'd0, d_done}, 32'd0);

        // Contention: the store goes first, then the fetch after one idle cycle.
        do_reset();
        if_req = 1; if_addr = 32'h40; d_write = 1; d_addr = 32'h200; d_wdata = 32'h55;
        tick();
        check("ct_st_we", {31'd0, m_we}, 32'd1);
        check("ct_st_addr", m_addr, 32'h200);
        check("ct_stall_if", {31'd0, stall_if}, 32'd1);
        m_ready = 1;
        tick();
        check("ct_st_done", {31'd0, d_done}, 32'd1);
        check("ct_turn_req", {31'd0, m_req}, 32'd0);
        d_write = 0; m_ready = 0;
        tick();
        check("ct_if_req", {31'd0, m_req}, 32'd1);
        check("ct_if_addr", m_addr, 32'h40);
        check("ct_if_we", {31'd0, m_we}, 32'd0);
        check("ct_if_wdata", m_wdata, 32'h55);
        m_ready = 1; m_rdata = 32'h1234_5678;
        tick();
        check("ct_if_valid", {31'd0, if_valid}, 32'd1);
        check("ct_if_rdata", if_rdata, 32'h1234_5678);
        check("ct_if_stall", {31'd0, stall_if}, 32'd0);
        check("ct_st_rdata", d_rdata, 32'h0);
        m_ready = 0;
        tick();
        check("ct_no_reissue", {31'd0, m_req}, 32'd0);
        check("ct_valid_pulse", {31'd0, if_valid}, 32'd0);
        if_req = 0;

        // Five wait states on the default-timeout instance.
        do_reset();
        d_write = 1; d_addr = 32'hA0; d_wdata = 32'h77;
        tick();
        d_addr = 32'hFFFF_0000; d_wdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("ws_addr[%0d]", k), l_m_addr, 32'hA0);
            check($sformatf("ws_wdata[%0d]", k), l_m_wdata, 32'h77);
            check($sformatf("ws_done[%0d]", k), {31'd0, l_d_done}, 32'd0);
        end
        m_ready = 1;
        tick();
        check("ws_done", {31'd0, l_d_done}, 32'd1);
        m_ready = 0;
        tick();
        check("ws_done_once", {31'd0, l_d_done}, 32'd0);
        check("ws_no_reissue", {31'd0, l_m_req}, 32'd0);
        check("ws_no_err", {31'd0, l_bus_err}, 32'd0);
        d_write = 0;

        // Timeout with TIMEOUT=4 and no m_ready.
        do_reset();
        d_read = 1; d_addr = 32'h10;
        tick();
        for (int k = 1; k < 4; k++) begin
            tick();
            check($sformatf("to_pre_err[%0d]", k), {31'd0, bus_err}, 32'd0);
            check($sformatf("to_pre_req[%0d]", k), {31'd0, m_req}, 32'd1);
        end
        tick();
        check("to_err", {31'd0, bus_err}, 32'd1);
        check("to_req", {31'd0, m_req}, 32'd0);
        d_read = 0; m_ready = 1;
        #1;
        check("to_stall_if", {31'd0, stall_if}, 32'd1);
        check("to_stall_mem", {31'd0, stall_mem}, 32'd1);
        tick();
        tick();
        check("to_absorb_done", {31'd0, d_done}, 32'd0);
        check("to_absorb_err", {31'd0, bus_err}, 32'd1);
        check("to_absorb_stall", {31'd0, stall_mem}, 32'd1);
        #2;
        rst = 1;
        #1;
        check("to_rst_err", {31'd0, bus_err}, 32'd0);
        check("to_rst_stall", {31'd0, stall_mem}, 32'd0);
        rst = 0;
        m_ready = 0;

        // Completion on the last allowed BUSY cycle wins over the timeout.
        do_reset();
        d_read = 1; d_addr = 32'h20;
        tick();
        tick(); tick(); tick();
        m_ready = 1; m_rdata = 32'hA5A5_0F0F;
        tick();
        check("bd_done", {31'd0, d_done}, 32'd1);
        check("bd_err", {31'd0, bus_err}, 32'd0);
        check("bd_rdata", d_rdata, 32'hA5A5_0F0F);
        d_read = 0; m_ready = 0;

        // Reset in the middle of a data access.
        do_reset();
        d_read = 1; d_addr = 32'h300;
        tick();
        tick();
        #3;
        rst = 1;
        #1;
        check("mr_req", {31'd0, m_req}, 32'd0);
        check("mr_addr", m_addr, 32'd0);
        d_read = 0; m_ready = 1; m_rdata = 32'h9999_9999;
        tick();
        rst = 0;
        tick();
        check("mr_no_done1", {31'd0, d_done}, 32'd0);
        tick();
        check("mr_no_done2", {31'd0, d_done}, 32'd0);
        check("mr_rdata", d_rdata, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
